// File: rtl/ctrl_pkg.sv
// Shared control-path definitions for the pipelined MIPS control unit:
// ALU op codes, opcode/func encodings, PC-source codes and the control bundle.
package ctrl_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PCSRC_PC4  = 2'd0;
  localparam logic [1:0] PCSRC_JUMP = 2'd2;
  localparam logic [1:0] PCSRC_JR   = 2'd3;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_LINK = 2'd3
  } dst_sel_e;

  // All-zero value is a bubble: no write, no memory access, pc+4
  typedef struct packed {
    logic                alusrc1;
    logic                alusrc2;
    logic [ALU_OP_W-1:0] aluop;
    logic                beq;
    logic                bne;
    logic [1:0]          pcsrc;
    logic                mem_read;
    logic                mem_write;
    logic                regwrite;
    logic                mem2reg;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage control decoder: opcode/func to control bundle, destination
// field select, rt-usage flag for hazard detection, and illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output ctrl_bundle_t bundle_c,
  output dst_sel_e     dst_sel_c,
  output logic         reads_rt_c,
  output logic         illegal_c
);

  always_comb begin
    bundle_c       = '0;
    bundle_c.pcsrc = PCSRC_PC4;
    dst_sel_c      = DST_NONE;
    reads_rt_c     = 1'b0;
    illegal_c      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reads_rt_c        = 1'b1;
        dst_sel_c         = DST_RD;
        bundle_c.regwrite = 1'b1;
        case (func)
          FN_ADD: bundle_c.aluop = ALU_ADD;
          FN_SUB: bundle_c.aluop = ALU_SUB;
          FN_AND: bundle_c.aluop = ALU_AND;
          FN_OR:  bundle_c.aluop = ALU_OR;
          FN_SLT: bundle_c.aluop = ALU_SLT;
          FN_SRL: begin
            bundle_c.aluop   = ALU_SRL;
            bundle_c.alusrc1 = 1'b1;
          end
          FN_JR: begin
            bundle_c.pcsrc    = PCSRC_JR;
            bundle_c.regwrite = 1'b0;
          end
          default: begin
            bundle_c.regwrite = 1'b0;
            illegal_c         = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
        dst_sel_c         = DST_RT;
        bundle_c.alusrc2  = 1'b1;
        bundle_c.regwrite = 1'b1;
        case (opcode)
          OP_ANDI: bundle_c.aluop = ALU_AND;
          OP_ORI:  bundle_c.aluop = ALU_OR;
          OP_SLTI: bundle_c.aluop = ALU_SLT;
          OP_LUI:  bundle_c.aluop = ALU_LUI;
          default: bundle_c.aluop = ALU_ADD;
        endcase
      end
      OP_LW: begin
        dst_sel_c         = DST_RT;
        bundle_c.alusrc2  = 1'b1;
        bundle_c.mem_read = 1'b1;
        bundle_c.regwrite = 1'b1;
        bundle_c.mem2reg  = 1'b1;
      end
      OP_SW: begin
        dst_sel_c          = DST_RT;
        reads_rt_c         = 1'b1;
        bundle_c.alusrc2   = 1'b1;
        bundle_c.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dst_sel_c      = DST_RT;
        reads_rt_c     = 1'b1;
        bundle_c.aluop = ALU_SUB;
        bundle_c.beq   = (opcode == OP_BEQ);
        bundle_c.bne   = (opcode == OP_BNE);
      end
      OP_J: bundle_c.pcsrc = PCSRC_JUMP;
      OP_JAL: begin
        dst_sel_c         = DST_LINK;
        bundle_c.pcsrc    = PCSRC_JUMP;
        bundle_c.regwrite = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and handles load-use stall, flush and freeze.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned ALU_W     = 4,
  parameter int unsigned LINK_REG  = 31,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush_ex,
  input  logic              mem_stall,
  output logic              stall_id,
  output logic              illegal,
  output logic              ex_alusrc1,
  output logic              ex_alusrc2,
  output logic [ALU_W-1:0]  ex_aluop,
  output logic              ex_beq,
  output logic              ex_bne,
  output logic [1:0]        ex_pcsrc,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_regwrite,
  output logic              wb_mem2reg,
  output logic [REG_AW-1:0] wb_wreg
);

  ctrl_bundle_t      dec_bundle;
  dst_sel_e          dec_dst;
  logic              dec_reads_rt;
  logic              dec_illegal;
  ctrl_bundle_t      id_bundle;
  logic [REG_AW-1:0] id_wreg;
  logic              stall_c;

  ctrl_bundle_t      ex_bundle_q, ex_bundle_d;
  logic [REG_AW-1:0] ex_wreg_q, ex_wreg_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_regwrite_q, mem_regwrite_d;
  logic              mem_mem2reg_q, mem_mem2reg_d;
  logic [REG_AW-1:0] mem_wreg_q, mem_wreg_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_mem2reg_q, wb_mem2reg_d;
  logic [REG_AW-1:0] wb_wreg_q, wb_wreg_d;
  logic              illegal_q, illegal_d;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .func       (func),
    .bundle_c   (dec_bundle),
    .dst_sel_c  (dec_dst),
    .reads_rt_c (dec_reads_rt),
    .illegal_c  (dec_illegal)
  );

  // Resolve destination register; writes to r0 are suppressed at the source
  always_comb begin
    id_bundle = dec_bundle;
    case (dec_dst)
      DST_RD:   id_wreg = id_rd;
      DST_RT:   id_wreg = id_rt;
      DST_LINK: id_wreg = REG_AW'(LINK_REG);
      default:  id_wreg = '0;
    endcase
    if (id_wreg == '0) id_bundle.regwrite = 1'b0;
  end

  // Load in EX whose result the ID instruction needs
  always_comb begin
    stall_c = 1'b0;
    if (HAZARD_EN && ex_bundle_q.mem_read && (ex_wreg_q != '0) && id_valid && !flush_ex)
      stall_c = (ex_wreg_q == id_rs) || ((ex_wreg_q == id_rt) && dec_reads_rt);
  end

  assign stall_id = stall_c;

  always_comb begin
    ex_bundle_d    = ex_bundle_q;
    ex_wreg_d      = ex_wreg_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_mem2reg_d  = mem_mem2reg_q;
    mem_wreg_d     = mem_wreg_q;
    wb_regwrite_d  = wb_regwrite_q;
    wb_mem2reg_d   = wb_mem2reg_q;
    wb_wreg_d      = wb_wreg_q;
    illegal_d      = 1'b0;
    if (!mem_stall) begin
      mem_read_d     = ex_bundle_q.mem_read;
      mem_write_d    = ex_bundle_q.mem_write;
      mem_regwrite_d = ex_bundle_q.regwrite;
      mem_mem2reg_d  = ex_bundle_q.mem2reg;
      mem_wreg_d     = ex_wreg_q;
      wb_regwrite_d  = mem_regwrite_q;
      wb_mem2reg_d   = mem_mem2reg_q;
      wb_wreg_d      = mem_wreg_q;
      if (flush_ex || stall_c || !id_valid || dec_illegal) begin
        ex_bundle_d = '0;
        ex_wreg_d   = '0;
        illegal_d   = id_valid && dec_illegal && !flush_ex && !stall_c;
      end else begin
        ex_bundle_d = id_bundle;
        ex_wreg_d   = id_wreg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_bundle_q    <= '0;
      ex_wreg_q      <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_mem2reg_q  <= 1'b0;
      mem_wreg_q     <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_mem2reg_q   <= 1'b0;
      wb_wreg_q      <= '0;
      illegal_q      <= 1'b0;
    end else begin
      ex_bundle_q    <= ex_bundle_d;
      ex_wreg_q      <= ex_wreg_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_mem2reg_q  <= mem_mem2reg_d;
      mem_wreg_q     <= mem_wreg_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_mem2reg_q   <= wb_mem2reg_d;
      wb_wreg_q      <= wb_wreg_d;
      illegal_q      <= illegal_d;
    end
  end

  assign illegal     = illegal_q;
  assign ex_alusrc1  = ex_bundle_q.alusrc1;
  assign ex_alusrc2  = ex_bundle_q.alusrc2;
  assign ex_aluop    = ALU_W'(ex_bundle_q.aluop);
  assign ex_beq      = ex_bundle_q.beq;
  assign ex_bne      = ex_bundle_q.bne;
  assign ex_pcsrc    = ex_bundle_q.pcsrc;
  assign ex_wreg     = ex_wreg_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wreg    = mem_wreg_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_mem2reg  = wb_mem2reg_q;
  assign wb_wreg     = wb_wreg_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus randomized instruction
// streams checked against a stage-by-stage instruction-level reference model.
module tb_pipe_ctrl_unit;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_W    = 4;
  localparam int unsigned LINK_REG = 31;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              id_valid;
  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              flush_ex;
  logic              mem_stall;
  logic              stall_id;
  logic              illegal;
  logic              ex_alusrc1;
  logic              ex_alusrc2;
  logic [ALU_W-1:0]  ex_aluop;
  logic              ex_beq;
  logic              ex_bne;
  logic [1:0]        ex_pcsrc;
  logic [REG_AW-1:0] ex_wreg;
  logic              mem_read;
  logic              mem_write;
  logic [REG_AW-1:0] mem_wreg;
  logic              wb_regwrite;
  logic              wb_mem2reg;
  logic [REG_AW-1:0] wb_wreg;

  pipe_ctrl_unit #(
    .REG_AW(REG_AW), .ALU_W(ALU_W), .LINK_REG(LINK_REG), .HAZARD_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opcode(opcode), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush_ex(flush_ex),
    .mem_stall(mem_stall), .stall_id(stall_id), .illegal(illegal),
    .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_aluop(ex_aluop),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_pcsrc(ex_pcsrc), .ex_wreg(ex_wreg),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_mem2reg(wb_mem2reg), .wb_wreg(wb_wreg)
  );

  always #5 clk = ~clk;

  // Expected effect of one instruction; all-zero is a bubble
  typedef struct {
    int alusrc1, alusrc2, aluop, beq, bne, pcsrc, wreg;
    int mrd, mwr, rw, m2r, rrt, ill;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t bubble = '{default: 0};
  exp_t m_ex, m_mem, m_wb;
  int   m_ill;
  bit   last_stall;
  logic stall_seen;
  bit   hold;

  task automatic check_val(input string tag, input logic [31:0] got, input int exp_v);
    total++;
    if (got !== 32'(exp_v)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp_v, $time);
    end
  endtask

  // Instruction semantics from the ISA table
  function automatic exp_t ref_decode(int op, int fn, int rt, int rd);
    exp_t e = '{default: 0};
    e.rrt = (op == 'h00 || op == 'h2B || op == 'h04 || op == 'h05) ? 1 : 0;
    case (op)
      'h00: begin
        e.wreg = rd; e.rw = 1;
        case (fn)
          'h20: e.aluop = 0;
          'h22: e.aluop = 1;
          'h24: e.aluop = 2;
          'h25: e.aluop = 3;
          'h2A: e.aluop = 4;
          'h02: begin e.aluop = 5; e.alusrc1 = 1; end
          'h08: begin e.pcsrc = 3; e.rw = 0; end
          default: e.ill = 1;
        endcase
      end
      'h08: begin e.alusrc2 = 1; e.rw = 1; e.wreg = rt; e.aluop = 0; end
      'h0C: begin e.alusrc2 = 1; e.rw = 1; e.wreg = rt; e.aluop = 2; end
      'h0D: begin e.alusrc2 = 1; e.rw = 1; e.wreg = rt; e.aluop = 3; end
      'h0A: begin e.alusrc2 = 1; e.rw = 1; e.wreg = rt; e.aluop = 4; end
      'h0F: begin e.alusrc2 = 1; e.rw = 1; e.wreg = rt; e.aluop = 6; end
      'h23: begin e.alusrc2 = 1; e.rw = 1; e.wreg = rt; e.mrd = 1; e.m2r = 1; end
      'h2B: begin e.alusrc2 = 1; e.wreg = rt; e.mwr = 1; end
      'h04: begin e.aluop = 1; e.beq = 1; e.wreg = rt; end
      'h05: begin e.aluop = 1; e.bne = 1; e.wreg = rt; end
      'h02: e.pcsrc = 2;
      'h03: begin e.pcsrc = 2; e.rw = 1; e.wreg = int'(LINK_REG); end
      default: e.ill = 1;
    endcase
    if (e.wreg == 0) e.rw = 0;
    return e;
  endfunction

  task automatic check_outputs();
    check_val("ex_alusrc1", 32'(ex_alusrc1), m_ex.alusrc1);
    check_val("ex_alusrc2", 32'(ex_alusrc2), m_ex.alusrc2);
    check_val("ex_aluop", 32'(ex_aluop), m_ex.aluop);
    check_val("ex_beq", 32'(ex_beq), m_ex.beq);
    check_val("ex_bne", 32'(ex_bne), m_ex.bne);
    check_val("ex_pcsrc", 32'(ex_pcsrc), m_ex.pcsrc);
    check_val("ex_wreg", 32'(ex_wreg), m_ex.wreg);
    check_val("mem_read", 32'(mem_read), m_mem.mrd);
    check_val("mem_write", 32'(mem_write), m_mem.mwr);
    check_val("mem_wreg", 32'(mem_wreg), m_mem.wreg);
    check_val("wb_regwrite", 32'(wb_regwrite), m_wb.rw);
    check_val("wb_mem2reg", 32'(wb_mem2reg), m_wb.m2r);
    check_val("wb_wreg", 32'(wb_wreg), m_wb.wreg);
    check_val("illegal", 32'(illegal), m_ill);
  endtask

  task automatic set_in(input int op, input int fn, input int rs, input int rt, input int rd,
                        input bit valid);
    opcode = 6'(op); func = 6'(fn);
    id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_rd = REG_AW'(rd);
    id_valid = valid;
  endtask

  // One clock: check stall_id mid-cycle, advance the model, check registered outputs
  task automatic cycle();
    exp_t d;
    bit   stall;
    d = ref_decode(int'(opcode), int'(func), int'(id_rt), int'(id_rd));
    stall = (m_ex.mrd != 0) && (m_ex.wreg != 0) && id_valid && !flush_ex &&
            ((m_ex.wreg == int'(id_rs)) || ((m_ex.wreg == int'(id_rt)) && (d.rrt != 0)));
    #1;
    stall_seen = stall_id;
    check_val("stall_id", 32'(stall_id), int'(stall));
    @(posedge clk);
    if (!mem_stall) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ill = (!flush_ex && !stall && id_valid && d.ill != 0) ? 1 : 0;
      if (flush_ex || stall || !id_valid || d.ill != 0) m_ex = bubble;
      else m_ex = d;
    end else begin
      m_ill = 0;
    end
    last_stall = stall;
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    m_ex = bubble; m_mem = bubble; m_wb = bubble; m_ill = 0;
    check_outputs();
    check_val("rst_stall", 32'(stall_id), 0);
    set_in(0, 0, 0, 0, 0, 1'b0);
    flush_ex = 1'b0; mem_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hold = 1'b0;
  endtask

  int ops[20] = '{'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h08, 'h0C, 'h0D,
                  'h0A, 'h0F, 'h23, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h03, 'h3F};
  int fns[8]  = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h02, 'h08, 'h3F};

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1'b0);
    flush_ex = 1'b0; mem_stall = 1'b0;
    m_ex = bubble; m_mem = bubble; m_wb = bubble; m_ill = 0;
    hold = 1'b0; last_stall = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // add r3,r1,r2
    set_in('h00, 'h20, 1, 2, 3, 1'b1);
    cycle();
    check_val("t1_ex_aluop", 32'(ex_aluop), 0);
    check_val("t1_ex_wreg", 32'(ex_wreg), 3);
    set_in(0, 0, 0, 0, 0, 1'b0);
    cycle(); cycle();
    check_val("t1_wb_regwrite", 32'(wb_regwrite), 1);
    check_val("t1_wb_wreg", 32'(wb_wreg), 3);

    // lw r5,0(r1); add r6,r5,r2 -> one stall cycle
    set_in('h23, 0, 1, 5, 0, 1'b1);
    cycle();
    set_in('h00, 'h20, 5, 2, 6, 1'b1);
    cycle();
    check_val("t2_stall", 32'(stall_seen), 1);
    check_val("t2_bubble_wreg", 32'(ex_wreg), 0);
    cycle();
    check_val("t2_stall_gone", 32'(stall_seen), 0);
    check_val("t2_add_wreg", 32'(ex_wreg), 6);

    // lw r0 then use r0: no stall; addi r0 never writes
    set_in('h23, 0, 1, 0, 0, 1'b1);
    cycle();
    set_in('h00, 'h20, 0, 0, 6, 1'b1);
    cycle();
    check_val("t3_no_stall", 32'(stall_seen), 0);
    set_in('h08, 0, 1, 0, 0, 1'b1);
    cycle();
    set_in(0, 0, 0, 0, 0, 1'b0);
    cycle(); cycle();
    check_val("t3_wb_regwrite", 32'(wb_regwrite), 0);

    // beq in EX with flush kills the following sw
    set_in('h04, 0, 1, 2, 0, 1'b1);
    cycle();
    check_val("t4_beq", 32'(ex_beq), 1);
    set_in('h2B, 0, 1, 2, 0, 1'b1);
    flush_ex = 1'b1;
    cycle();
    flush_ex = 1'b0;
    check_val("t4_flushed_beq", 32'(ex_beq), 0);
    set_in(0, 0, 0, 0, 0, 1'b0);
    cycle();
    check_val("t4_mem_write", 32'(mem_write), 0);

    // Freeze for three cycles mid-stream
    set_in('h00, 'h20, 1, 2, 7, 1'b1); cycle();
    set_in('h23, 0, 1, 8, 0, 1'b1);    cycle();
    set_in('h0D, 0, 1, 9, 0, 1'b1);
    mem_stall = 1'b1;
    cycle(); cycle(); cycle();
    mem_stall = 1'b0;
    cycle(); cycle(); cycle();

    // Undecodable opcode, then reset mid-stream
    set_in('h3F, 0, 1, 2, 3, 1'b1);
    cycle();
    check_val("t6_illegal", 32'(illegal), 1);
    set_in('h00, 'h20, 1, 2, 4, 1'b1);
    cycle();
    check_val("t6_illegal_pulse", 32'(illegal), 0);
    set_in('h23, 0, 1, 5, 0, 1'b1);
    cycle();
    do_reset();

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if (!hold) begin
        int op;
        op = ops[$urandom_range(0, 19)];
        set_in(op, (op == 0) ? fns[$urandom_range(0, 7)] : int'($urandom_range(0, 63)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0));
      end
      flush_ex  = ($urandom_range(0, 99) < 8);
      mem_stall = ($urandom_range(0, 99) < 10);
      cycle();
      hold = (last_stall || mem_stall) && !flush_ex;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
